// File: rtl/shifter_seq_ctrl.sv
// Multi-pass controller that time-shares one 16-bit/4-bit right shifter between two requesters,
// extending the shift range to 0..63 with round-robin arbitration and valid/ready handshakes.
module shifter_seq_ctrl #(
    parameter int OPERAND_WIDTH = 16,
    parameter int SHAMT_WIDTH   = 4,
    parameter int AMT_WIDTH     = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [OPERAND_WIDTH-1:0] req0_in,
    input  logic [AMT_WIDTH-1:0]     req0_amt,
    input  logic                     req0_oper,
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic [OPERAND_WIDTH-1:0] req1_in,
    input  logic [AMT_WIDTH-1:0]     req1_amt,
    input  logic                     req1_oper,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [OPERAND_WIDTH-1:0] resp_out,
    output logic                     resp_id,
    output logic                     busy,
    output logic [OPERAND_WIDTH-1:0] sh_in,
    output logic [SHAMT_WIDTH-1:0]   sh_shamt,
    output logic                     sh_oper,
    input  logic [OPERAND_WIDTH-1:0] sh_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [AMT_WIDTH-1:0] MAX_CHUNK = AMT_WIDTH'((1 << SHAMT_WIDTH) - 1);

    state_t                   state_r;
    logic [OPERAND_WIDTH-1:0] acc_r;
    logic [AMT_WIDTH-1:0]     rem_r;
    logic                     oper_r;
    logic                     id_r;
    logic                     rr_ptr_r;

    logic                     grant_valid_s;
    logic                     grant_id_s;
    logic [OPERAND_WIDTH-1:0] sel_in_s;
    logic [AMT_WIDTH-1:0]     sel_amt_s;
    logic                     sel_oper_s;
    logic [AMT_WIDTH-1:0]     chunk_s;

    // Arbitration: a lone requester wins; on a tie rr_ptr picks the winner.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_id_s    = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_valid_s = 1'b1;
            grant_id_s    = rr_ptr_r;
        end else if (req0_valid) begin
            grant_valid_s = 1'b1;
            grant_id_s    = 1'b0;
        end else if (req1_valid) begin
            grant_valid_s = 1'b1;
            grant_id_s    = 1'b1;
        end else begin
            grant_valid_s = 1'b0;
            grant_id_s    = 1'b0;
        end
    end

    // Request fields of the granted port.
    always_comb begin
        sel_in_s   = req0_in;
        sel_amt_s  = req0_amt;
        sel_oper_s = req0_oper;
        if (grant_id_s) begin
            sel_in_s   = req1_in;
            sel_amt_s  = req1_amt;
            sel_oper_s = req1_oper;
        end else begin
            sel_in_s   = req0_in;
            sel_amt_s  = req0_amt;
            sel_oper_s = req0_oper;
        end
    end

    // Per-pass amount: the largest chunk the shifter can do, capped by what remains.
    always_comb begin
        chunk_s = rem_r;
        if (rem_r > MAX_CHUNK) begin
            chunk_s = MAX_CHUNK;
        end else begin
            chunk_s = rem_r;
        end
    end

    // Sequencer: accept, iterate passes through the shifter, then hold the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            acc_r    <= {OPERAND_WIDTH{1'b0}};
            rem_r    <= {AMT_WIDTH{1'b0}};
            oper_r   <= 1'b0;
            id_r     <= 1'b0;
            rr_ptr_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_valid_s) begin
                        acc_r    <= sel_in_s;
                        rem_r    <= sel_amt_s;
                        oper_r   <= sel_oper_s;
                        id_r     <= grant_id_s;
                        rr_ptr_r <= ~grant_id_s;
                        state_r  <= (sel_amt_s != {AMT_WIDTH{1'b0}}) ? SHIFT : DONE;
                    end
                end
                SHIFT: begin
                    acc_r <= sh_out;
                    rem_r <= rem_r - chunk_s;
                    if (rem_r == chunk_s) begin
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Ready is gated by rst so every output reads 0 while reset is held.
    assign req0_ready = !rst && (state_r == IDLE) && grant_valid_s && (grant_id_s == 1'b0);
    assign req1_ready = !rst && (state_r == IDLE) && grant_valid_s && (grant_id_s == 1'b1);

    assign resp_valid = (state_r == DONE);
    assign resp_out   = (state_r == DONE) ? acc_r : {OPERAND_WIDTH{1'b0}};
    assign resp_id    = (state_r == DONE) ? id_r : 1'b0;
    assign busy       = (state_r != IDLE);

    // Outside SHIFT the shifter sees amount 0 and passes acc through.
    assign sh_in    = acc_r;
    assign sh_oper  = oper_r;
    assign sh_shamt = (state_r == SHIFT) ? chunk_s[SHAMT_WIDTH-1:0] : {SHAMT_WIDTH{1'b0}};

endmodule

// File: tb/tb_shifter_seq_ctrl.sv
// Directed bench for shifter_seq_ctrl with a behavioural model of the external shifter.
module tb_shifter_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [15:0] req0_in = 16'h0000, req1_in = 16'h0000;
    logic [5:0]  req0_amt = 6'd0, req1_amt = 6'd0;
    logic        req0_oper = 1'b0, req1_oper = 1'b0;
    logic        resp_valid, resp_id, busy, sh_oper;
    logic        resp_ready = 1'b0;
    logic [15:0] resp_out, sh_in, sh_out;
    logic [3:0]  sh_shamt;
    logic [31:0] dbl_s;

    int n_checks = 0;
    int n_pass   = 0;
    logic [3:0] pass_log[$];

    shifter_seq_ctrl dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_in(req0_in),
        .req0_amt(req0_amt), .req0_oper(req0_oper),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_in(req1_in),
        .req1_amt(req1_amt), .req1_oper(req1_oper),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_out(resp_out),
        .resp_id(resp_id), .busy(busy),
        .sh_in(sh_in), .sh_shamt(sh_shamt), .sh_oper(sh_oper), .sh_out(sh_out)
    );

    always #5 clk = ~clk;

    // External shifter: rotate right or logical right by sh_shamt.
    always_comb begin
        dbl_s  = {sh_in, sh_in} >> sh_shamt;
        sh_out = sh_oper ? (sh_in >> sh_shamt) : dbl_s[15:0];
    end

    // Record every non-zero pass amount driven to the shifter.
    always @(negedge clk) begin
        if (sh_shamt != 4'd0) pass_log.push_back(sh_shamt);
    end

    // Issue one request on a port, wait for its response, and pop it.
    task automatic run_txn(input logic port, input logic [15:0] din, input logic [5:0] amt,
                           input logic op, output int lat, output logic [15:0] out,
                           output logic rid, output bit ok);
        ok = 1'b0; lat = 0; out = 16'h0000; rid = 1'b0;
        pass_log.delete();
        resp_ready = 1'b0;
        if (port) begin
            req1_valid = 1'b1; req1_in = din; req1_amt = amt; req1_oper = op;
        end else begin
            req0_valid = 1'b1; req0_in = din; req0_amt = amt; req0_oper = op;
        end
        for (int i = 0; i < 20; i++) begin
            #1;
            if ((port && req1_ready) || (!port && req0_ready)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            @(negedge clk);
            req0_valid = 1'b0; req1_valid = 1'b0;
            ok = 1'b0;
            lat = 1;
            for (int i = 0; i < 30; i++) begin
                if (resp_valid) begin
                    ok = 1'b1;
                    break;
                end
                @(negedge clk);
                lat++;
            end
            out = resp_out;
            rid = resp_id;
            resp_ready = 1'b1;
            @(negedge clk);
            resp_ready = 1'b0;
        end else begin
            req0_valid = 1'b0; req1_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1; req0_amt = 6'd5; req1_amt = 6'd5;
        req0_in = 16'hABCD; req1_in = 16'h1357;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({req0_ready, req1_ready, resp_valid, busy} !== 4'b0000)
            $display("FAIL reset_ctrl: got rdy0/rdy1/vld/busy=%b required 0000",
                     {req0_ready, req1_ready, resp_valid, busy});
        else n_pass++;
        n_checks++;
        if ({resp_out, sh_in} !== 32'h0) $display("FAIL reset_data: got resp_out=%h sh_in=%h required 0", resp_out, sh_in);
        else n_pass++;
        n_checks++;
        if ({sh_shamt, sh_oper, resp_id} !== 6'b0) $display("FAIL reset_sh: got shamt=%h oper=%b id=%b required 0", sh_shamt, sh_oper, resp_id);
        else n_pass++;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_rotate_basic();
        int lat; logic [15:0] out; logic rid; bit ok;
        run_txn(1'b0, 16'h8001, 6'd1, 1'b0, lat, out, rid, ok);
        n_checks++;
        if (!ok || out !== 16'hC000 || rid !== 1'b0) $display("FAIL rot1_result: got ok=%0d out=%h id=%b required out=c000 id=0", ok, out, rid);
        else n_pass++;
        n_checks++;
        if (lat !== 2) $display("FAIL rot1_latency: got %0d required 2", lat);
        else n_pass++;
        n_checks++;
        if (pass_log.size() != 1 || pass_log[0] !== 4'd1) $display("FAIL rot1_passes: got %0d passes required one pass of 1", pass_log.size());
        else n_pass++;
    endtask

    task automatic test_logical_multi();
        int lat; logic [15:0] out; logic rid; bit ok;
        run_txn(1'b1, 16'hFFFF, 6'd20, 1'b1, lat, out, rid, ok);
        n_checks++;
        if (!ok || out !== 16'h0000 || rid !== 1'b1) $display("FAIL lsr20_result: got ok=%0d out=%h id=%b required out=0000 id=1", ok, out, rid);
        else n_pass++;
        n_checks++;
        if (lat !== 3) $display("FAIL lsr20_latency: got %0d required 3", lat);
        else n_pass++;
        n_checks++;
        if (pass_log.size() != 2 || pass_log[0] !== 4'd15 || pass_log[1] !== 4'd5)
            $display("FAIL lsr20_passes: got %0d passes required 15,5", pass_log.size());
        else n_pass++;
        // A narrower logical shift must keep the upper bits that survive.
        run_txn(1'b1, 16'hF0F0, 6'd4, 1'b1, lat, out, rid, ok);
        n_checks++;
        if (!ok || out !== 16'h0F0F || lat !== 2) $display("FAIL lsr4: got out=%h lat=%0d required 0f0f lat 2", out, lat);
        else n_pass++;
    endtask

    task automatic test_long_and_zero();
        int lat; logic [15:0] out; logic rid; bit ok;
        run_txn(1'b0, 16'h1234, 6'd33, 1'b0, lat, out, rid, ok);
        n_checks++;
        if (!ok || out !== 16'h091A || lat !== 4) $display("FAIL rot33: got out=%h lat=%0d required 091a lat 4", out, lat);
        else n_pass++;
        n_checks++;
        if (pass_log.size() != 3 || pass_log[0] !== 4'd15 || pass_log[1] !== 4'd15 || pass_log[2] !== 4'd3)
            $display("FAIL rot33_passes: got %0d passes required 15,15,3", pass_log.size());
        else n_pass++;
        run_txn(1'b0, 16'h1234, 6'd0, 1'b0, lat, out, rid, ok);
        n_checks++;
        if (!ok || out !== 16'h1234 || lat !== 1 || pass_log.size() != 0)
            $display("FAIL amt0: got out=%h lat=%0d passes=%0d required 1234 lat 1 passes 0", out, lat, pass_log.size());
        else n_pass++;
        run_txn(1'b1, 16'h1234, 6'd63, 1'b0, lat, out, rid, ok);
        n_checks++;
        if (!ok || out !== 16'h2468 || lat !== 6 || rid !== 1'b1 || pass_log.size() != 5)
            $display("FAIL rot63: got out=%h lat=%0d id=%b passes=%0d required 2468 lat 6 id 1 passes 5", out, lat, rid, pass_log.size());
        else n_pass++;
        run_txn(1'b0, 16'hFFFF, 6'd16, 1'b1, lat, out, rid, ok);
        n_checks++;
        if (!ok || out !== 16'h0000 || lat !== 3) $display("FAIL lsr16: got out=%h lat=%0d required 0000 lat 3", out, lat);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic grants[$]; logic ids[$]; logic [15:0] outs[$];
        bit both_seen = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req0_in = 16'h0003; req0_amt = 6'd1; req0_oper = 1'b0;
        req1_in = 16'h00F0; req1_amt = 6'd4; req1_oper = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b1;
        for (int i = 0; i < 80 && ids.size() < 4; i++) begin
            #1;
            if (req0_ready && req1_ready) both_seen = 1'b1;
            if (req0_ready) grants.push_back(1'b0);
            if (req1_ready) grants.push_back(1'b1);
            if (resp_valid) begin
                ids.push_back(resp_id);
                outs.push_back(resp_out);
            end
            if (ids.size() == 4) begin
                req0_valid = 1'b0; req1_valid = 1'b0;
            end
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
        n_checks++;
        if (grants.size() != 4 || ids.size() != 4 || both_seen)
            $display("FAIL rr_count: got grants=%0d resps=%0d both_ready=%0d required 4,4,0", grants.size(), ids.size(), both_seen);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            logic exp_g;
            logic [15:0] exp_o;
            exp_g = (i % 2 == 1) ? 1'b1 : 1'b0;
            exp_o = exp_g ? 16'h000F : 16'h8001;
            n_checks++;
            if (i >= grants.size() || i >= ids.size() || grants[i] !== exp_g || ids[i] !== exp_g || outs[i] !== exp_o)
                $display("FAIL rr_order[%0d]: got grant/id/out mismatch required id=%b out=%h", i, exp_g, exp_o);
            else n_pass++;
        end
        @(negedge clk);
    endtask

    task automatic test_stall();
        bit ok = 1'b0;
        bit stable = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_in = 16'h1234; req1_amt = 6'd8; req1_oper = 1'b0;
        resp_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (req1_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        req1_valid = 1'b0;
        for (int i = 0; i < 20 && !resp_valid; i++) @(negedge clk);
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_in = 16'hBEEF; req0_amt = 6'd0; req1_amt = 6'd0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (!resp_valid || resp_out !== 16'h3412 || resp_id !== 1'b1 || req0_ready || req1_ready) stable = 1'b0;
            @(negedge clk);
        end
        n_checks++;
        if (!ok || !stable) $display("FAIL stall_hold: got accepted=%0d stable=%0d required 1,1 (out 3412 id 1, readies 0)", ok, stable);
        else n_pass++;
        resp_ready = 1'b1;
        #1;
        n_checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) $display("FAIL done_no_accept: got rdy0=%b rdy1=%b required 0,0", req0_ready, req1_ready);
        else n_pass++;
        @(negedge clk);
        resp_ready = 1'b0;
        #1;
        n_checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) $display("FAIL rr_after_stall: got rdy0=%b rdy1=%b required 1,0", req0_ready, req1_ready);
        else n_pass++;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit got = 1'b0;
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_in = 16'hFFFF; req0_amt = 6'd63; req0_oper = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (req0_ready) break;
            @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b1 || sh_shamt !== 4'd15) $display("FAIL mid_shift: got busy=%b shamt=%0d required 1,15", busy, sh_shamt);
        else n_pass++;
        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_in = 16'hBEEF; req0_amt = 6'd0; req0_oper = 1'b0;
        req1_in = 16'h5555; req1_amt = 6'd0;
        #1;
        n_checks++;
        if ({busy, resp_valid, req0_ready, req1_ready, sh_shamt, sh_in, resp_out} !== 36'h0)
            $display("FAIL rst_mid: got busy=%b vld=%b rdy=%b%b shamt=%h sh_in=%h out=%h required all 0",
                     busy, resp_valid, req0_ready, req1_ready, sh_shamt, sh_in, resp_out);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) $display("FAIL rst_grant: got rdy0=%b rdy1=%b required 1,0", req0_ready, req1_ready);
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (resp_valid) begin got = 1'b1; break; end
            @(negedge clk);
        end
        n_checks++;
        if (!got || resp_out !== 16'hBEEF || resp_id !== 1'b0) $display("FAIL rst_after: got vld=%0d out=%h id=%b required 1 beef 0", got, resp_out, resp_id);
        else n_pass++;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rotate_basic();
        test_logical_multi();
        test_long_and_zero();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
